video_out_formatter: RTL

- Parametrised successor to the fixed RGB332-to-36-bit video colour hookup in the KV260 top level.
- Sits between the SoC VGA timing/colour outputs and the DisplayPort live-video input.
- Expands packed RGB of any component width to OUT_BPC bits per component using true bit replication. Applies sync polarity and blanking.
- Adds frame-synchronous mode switching: passthrough, colour bars, solid colour. Adds a frame counter.

---
 rtl/video_out_formatter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/video_out_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : video_out_formatter
//  Description : Two-stage video output formatter. Expands packed RGB to
//                OUT_BPC bits per component by bit replication, applies sync
//                polarity and blanking, and switches between passthrough,
//                colour bars and solid colour on vsync rising edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_out_formatter #(
    parameter int IN_R_W        = 3,
    parameter int IN_G_W        = 3,
    parameter int IN_B_W        = 2,
    parameter int OUT_BPC       = 12,
    parameter int BAR_W         = 80,
    parameter int HS_ACTIVE_LOW = 1,
    parameter int VS_ACTIVE_LOW = 1
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              in_de,
    input  logic                              in_hs,
    input  logic                              in_vs,
    input  logic [IN_R_W+IN_G_W+IN_B_W-1:0]   in_color,
    input  logic [1:0]                        mode_req,
    input  logic [3*OUT_BPC-1:0]              solid_color,
    output logic                              out_de,
    output logic                              out_hs,
    output logic                              out_vs,
    output logic [3*OUT_BPC-1:0]              out_color,
    output logic [1:0]                        mode_active,
    output logic [15:0]                       frame_count
);

    localparam int c_IN_W  = IN_R_W + IN_G_W + IN_B_W;
    localparam int c_PIX_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [c_PIX_W-1:0] c_PIX_LAST = c_PIX_W'(BAR_W - 1);

    localparam logic [1:0] c_MODE_PASS  = 2'd0;
    localparam logic [1:0] c_MODE_BARS  = 2'd1;
    localparam logic [1:0] c_MODE_SOLID = 2'd2;

    localparam logic c_HS_INV = (HS_ACTIVE_LOW != 0);
    localparam logic c_VS_INV = (VS_ACTIVE_LOW != 0);

    // Frame-level control state
    logic                 r_vs_prev;
    logic [1:0]           r_mode;
    logic [3*OUT_BPC-1:0] r_solid;
    logic [15:0]          r_frame_count;

    // Bar position counters
    logic [c_PIX_W-1:0]   r_bar_pix;
    logic [2:0]           r_bar_idx;

    // Stage 1
    logic                 r_de1, r_hs1, r_vs1;
    logic [c_IN_W-1:0]    r_color1;
    logic [2:0]           r_bar1;
    logic [1:0]           r_mode1;
    logic [3*OUT_BPC-1:0] r_solid1;

    // Stage 2
    logic                 r_de2, r_hs2, r_vs2;
    logic [3*OUT_BPC-1:0] r_color2;

    logic                 w_vs_rise;
    logic [1:0]           w_mode_sane;
    logic [OUT_BPC-1:0]   w_exp_r, w_exp_g, w_exp_b;
    logic [3*OUT_BPC-1:0] w_bar_color;
    logic [3*OUT_BPC-1:0] w_src_color;

    assign w_vs_rise   = in_vs & ~r_vs_prev;
    assign w_mode_sane = (mode_req == c_MODE_BARS || mode_req == c_MODE_SOLID) ? mode_req : c_MODE_PASS;

    // Replicate each component MSB-first; output bit i takes input bit (i mod W) from the top.
    generate
        for (genvar i = 0; i < OUT_BPC; i++) begin : g_expand
            assign w_exp_r[OUT_BPC-1-i] = r_color1[c_IN_W-1-(i % IN_R_W)];
            assign w_exp_g[OUT_BPC-1-i] = r_color1[IN_G_W+IN_B_W-1-(i % IN_G_W)];
            assign w_exp_b[OUT_BPC-1-i] = r_color1[IN_B_W-1-(i % IN_B_W)];
        end
    endgenerate

    assign w_bar_color = {{OUT_BPC{r_bar1[0]}}, {OUT_BPC{r_bar1[2]}}, {OUT_BPC{r_bar1[1]}}};

    // Select the colour source using the mode that was in force when the pixel was sampled
    always_comb begin
        w_src_color = '0;
        case (r_mode1)
            c_MODE_BARS:  w_src_color = w_bar_color;
            c_MODE_SOLID: w_src_color = r_solid1;
            default:      w_src_color = {w_exp_b, w_exp_r, w_exp_g};
        endcase
    end

    // Vsync edge detection; latch mode and solid colour and count frames on each rising edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vs_prev     <= 1'b1;
            r_mode        <= c_MODE_PASS;
            r_solid       <= '0;
            r_frame_count <= '0;
        end else begin
            r_vs_prev <= in_vs;
            if (w_vs_rise) begin
                r_mode        <= w_mode_sane;
                r_solid       <= solid_color;
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    // Horizontal bar position: held at zero while blanked, advances per active pixel
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bar_pix <= '0;
            r_bar_idx <= '0;
        end else if (!in_de) begin
            r_bar_pix <= '0;
            r_bar_idx <= '0;
        end else if (r_bar_pix == c_PIX_LAST) begin
            r_bar_pix <= '0;
            r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
            r_bar_pix <= r_bar_pix + 1'b1;
        end
    end

    // Stage 1: capture timing, colour, bar index and the mode in force for this pixel
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_de1    <= 1'b0;
            r_hs1    <= 1'b0;
            r_vs1    <= 1'b0;
            r_color1 <= '0;
            r_bar1   <= '0;
            r_mode1  <= c_MODE_PASS;
            r_solid1 <= '0;
        end else begin
            r_de1    <= in_de;
            r_hs1    <= in_hs;
            r_vs1    <= in_vs;
            r_color1 <= in_color;
            r_bar1   <= r_bar_idx;
            r_mode1  <= r_mode;
            r_solid1 <= r_solid;
        end
    end

    // Stage 2: final colour with blanking, aligned timing
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_de2    <= 1'b0;
            r_hs2    <= 1'b0;
            r_vs2    <= 1'b0;
            r_color2 <= '0;
        end else begin
            r_de2    <= r_de1;
            r_hs2    <= r_hs1;
            r_vs2    <= r_vs1;
            r_color2 <= r_de1 ? w_src_color : '0;
        end
    end

    assign out_de      = r_de2;
    assign out_hs      = r_hs2 ^ c_HS_INV;
    assign out_vs      = r_vs2 ^ c_VS_INV;
    assign out_color   = r_color2;
    assign mode_active = r_mode;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire
